// File: rtl/collision_game_state.sv
// ==========================================================================
// collision_game_state: pixel collision detector plus per-frame game state
// (alive matrix, score, lives, phase). Optional macro: SCORE_ROW_WEIGHT_EN.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module collision_game_state #(
  parameter int NUM_ROWS       = 3,
  parameter int NUM_COLUMNS    = 5,
  parameter int SPACING_X_LOG2 = 6,
  parameter int SPACING_Y_LOG2 = 5,
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int WAVE_FRAMES    = 90
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vsync,
  input  logic                          display_on,
  input  logic [9:0]                    pix_x,
  input  logic [9:0]                    pix_y,
  input  logic [9:0]                    formation_x,
  input  logic [9:0]                    formation_y,
  input  logic                          laser_gfx,
  input  logic                          alien_pixel,
  input  logic                          bomb_gfx,
  input  logic                          cannon_gfx,
  input  logic                          restart,
  output logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
  output logic                          hit_alien,
  output logic [7:0]                    score,
  output logic [1:0]                    lives,
  output logic                          cannon_dead,
  output logic                          game_over
);

  localparam int CELLS  = NUM_ROWS * NUM_COLUMNS;
  localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int RSP_W  = $clog2(RESPAWN_FRAMES + 1);
  localparam int WAV_W  = $clog2(WAVE_FRAMES + 1);
  localparam logic [CELLS-1:0] ALL_ALIVE = {CELLS{1'b1}};
  localparam logic [9:0] COLS_10 = 10'(NUM_COLUMNS);
  localparam logic [9:0] ROWS_10 = 10'(NUM_ROWS);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WAVE = 2'd1,
    OVER = 2'd2
  } phase_t;

  phase_t             phase;
  logic               vsync_q;
  logic               pending_kill;
  logic               pending_death;
  logic [IDX_W-1:0]   kill_idx;
  logic [RSP_W-1:0]   respawn_cnt;
  logic [WAV_W-1:0]   wave_cnt;

  logic               frame_tick;
  logic [9:0]         dx, dy, col_full, row_full;
  logic               in_grid;
  logic [IDX_W-1:0]   cell_idx;
  logic               kill_ok;
  logic [CELLS-1:0]   alive_after;
  logic [1:0]         lives_after;
  logic [7:0]         points;
  logic [8:0]         score_sum;
  logic [7:0]         score_sat;

  assign frame_tick = vsync_q & ~vsync;

  // Cell lookup uses 10-bit wrapping subtraction; negative offsets are rejected explicitly.
  assign dx       = pix_x - formation_x;
  assign dy       = pix_y - formation_y;
  assign col_full = dx >> SPACING_X_LOG2;
  assign row_full = dy >> SPACING_Y_LOG2;
  assign in_grid  = (pix_x >= formation_x) && (pix_y >= formation_y) &&
                    (col_full < COLS_10) && (row_full < ROWS_10);
  assign cell_idx = IDX_W'(row_full * COLS_10 + col_full);

  assign kill_ok     = pending_kill & alive_matrix[kill_idx];
  assign alive_after = alive_matrix & ~(CELLS'(kill_ok) << kill_idx);
  assign lives_after = (pending_death && lives != 2'd0) ? lives - 2'd1 : lives;

`ifdef SCORE_ROW_WEIGHT_EN
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  logic [ROW_W-1:0] kill_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_row <= '0;
    end else if (!frame_tick && display_on && phase == PLAY && !pending_kill &&
                 laser_gfx && alien_pixel && in_grid) begin
      kill_row <= ROW_W'(row_full);
    end
  end

  assign points = 8'(NUM_ROWS) - 8'(kill_row);
`else
  assign points = 8'd1;
`endif

  assign score_sum = {1'b0, score} + {1'b0, points};
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase         <= PLAY;
      vsync_q       <= 1'b1;
      pending_kill  <= 1'b0;
      pending_death <= 1'b0;
      kill_idx      <= '0;
      respawn_cnt   <= '0;
      wave_cnt      <= '0;
      alive_matrix  <= ALL_ALIVE;
      hit_alien     <= 1'b0;
      score         <= 8'd0;
      lives         <= 2'(START_LIVES);
      cannon_dead   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (frame_tick) begin
        pending_kill  <= 1'b0;
        pending_death <= 1'b0;
        hit_alien     <= 1'b0;
        if (cannon_dead) begin
          if (respawn_cnt <= RSP_W'(1)) begin
            cannon_dead <= 1'b0;
            respawn_cnt <= '0;
          end else begin
            respawn_cnt <= respawn_cnt - RSP_W'(1);
          end
        end
        case (phase)
          PLAY: begin
            alive_matrix <= alive_after;
            hit_alien    <= kill_ok;
            if (kill_ok) score <= score_sat;
            if (pending_death) begin
              lives       <= lives_after;
              cannon_dead <= 1'b1;
              respawn_cnt <= RSP_W'(RESPAWN_FRAMES);
            end
            if (pending_death && lives_after == 2'd0) begin
              phase     <= OVER;
              game_over <= 1'b1;
            end else if (alive_after == '0) begin
              phase    <= WAVE;
              wave_cnt <= WAV_W'(WAVE_FRAMES);
            end
          end
          WAVE: begin
            if (wave_cnt <= WAV_W'(1)) begin
              phase        <= PLAY;
              wave_cnt     <= '0;
              alive_matrix <= ALL_ALIVE;
            end else begin
              wave_cnt <= wave_cnt - WAV_W'(1);
            end
          end
          OVER: begin
            if (restart) begin
              phase        <= PLAY;
              game_over    <= 1'b0;
              score        <= 8'd0;
              lives        <= 2'(START_LIVES);
              alive_matrix <= ALL_ALIVE;
              cannon_dead  <= 1'b0;
              respawn_cnt  <= '0;
            end
          end
          default: phase <= PLAY;
        endcase
      end else if (display_on && phase == PLAY) begin
        if (!pending_kill && laser_gfx && alien_pixel && in_grid) begin
          pending_kill <= 1'b1;
          kill_idx     <= cell_idx;
        end
        if (!cannon_dead && bomb_gfx && cannon_gfx) pending_death <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_collision_game_state.sv
// Directed bench for collision_game_state: kills, deaths, respawn, wave reload, game over, saturation.
`default_nettype none

module tb_collision_game_state;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b1;
  logic        display_on = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic [9:0]  formation_x = 10'd100, formation_y = 10'd50;
  logic        laser_gfx = 1'b0, alien_pixel = 1'b0, bomb_gfx = 1'b0, cannon_gfx = 1'b0;
  logic        restart = 1'b0;
  logic [14:0] alive_matrix;
  logic        hit_alien;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        cannon_dead;
  logic        game_over;

  int vectors = 0;
  int miscompares = 0;
  logic [14:0] m_alive = 15'h7FFF;
  int          m_score = 0;

  collision_game_state dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .display_on(display_on),
    .pix_x(pix_x), .pix_y(pix_y), .formation_x(formation_x), .formation_y(formation_y),
    .laser_gfx(laser_gfx), .alien_pixel(alien_pixel), .bomb_gfx(bomb_gfx),
    .cannon_gfx(cannon_gfx), .restart(restart), .alive_matrix(alive_matrix),
    .hit_alien(hit_alien), .score(score), .lives(lives), .cannon_dead(cannon_dead),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int pts(input int r);
`ifdef SCORE_ROW_WEIGHT_EN
    return 3 - r;
`else
    return 1;
`endif
  endfunction

  function automatic int cx(input int c); return 100 + c * 64 + 5; endfunction
  function automatic int cy(input int r); return 50 + r * 32 + 5; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic l, input logic a,
                     input logic b, input logic c, input logic d = 1'b1);
    @(negedge clk);
    display_on = d; pix_x = 10'(x); pix_y = 10'(y);
    laser_gfx = l; alien_pixel = a; bomb_gfx = b; cannon_gfx = c;
    @(negedge clk);
    display_on = 1'b0; laser_gfx = 1'b0; alien_pixel = 1'b0; bomb_gfx = 1'b0; cannon_gfx = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
  endtask

  // One-frame kill attempt on cell (r,c) with the bench's own expectation.
  task automatic kill(input int r, input int c);
    int  idx;
    logic exp_hit;
    idx = r * 5 + c;
    pix(cx(c), cy(r), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp_hit = m_alive[idx];
    if (exp_hit) begin
      m_alive[idx] = 1'b0;
      m_score = (m_score + pts(r) > 255) ? 255 : m_score + pts(r);
    end
    chk("kill_alive", 32'(alive_matrix), 32'(m_alive));
    chk("kill_hit", 32'(hit_alien), 32'(exp_hit));
    chk("kill_score", 32'(score), 32'(m_score));
  endtask

  task automatic wave_wait();
    repeat (90) tick();
    m_alive = 15'h7FFF;
    chk("wave_reload", 32'(alive_matrix), 32'h7FFF);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_alive", 32'(alive_matrix), 32'h7FFF);
    chk("rst_hit", 32'(hit_alien), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_dead", 32'(cannon_dead), 0);
    chk("rst_over", 32'(game_over), 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_alive", 32'(alive_matrix), 32'h7FFF);
    chk("idle_score", 32'(score), 0);
    chk("idle_lives", 32'(lives), 3);
    chk("idle_hit", 32'(hit_alien), 0);

    // Overlap at pixel (170,60) -> row 0, col 1
    pix(170, 60, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_alive = 15'h7FFD; m_score = pts(0);
    chk("t2_alive", 32'(alive_matrix), 32'h7FFD);
    chk("t2_hit", 32'(hit_alien), 1);
    chk("t2_score", 32'(score), 32'(pts(0)));
    tick();
    chk("t2_hit_drop", 32'(hit_alien), 0);

    // Two overlaps in one frame: only (1,2) counts
    pix(cx(2), cy(1), 1'b1, 1'b1, 1'b0, 1'b0);
    pix(cx(0), cy(2), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_alive[7] = 1'b0; m_score += pts(1);
    chk("t3_alive", 32'(alive_matrix), 32'(m_alive));
    chk("t3_score", 32'(score), 32'(m_score));

    // Out-of-grid and blanked overlaps are ignored; the later valid one latches
    pix(95, cy(0), 1'b1, 1'b1, 1'b0, 1'b0);
    pix(cx(5), cy(0), 1'b1, 1'b1, 1'b0, 1'b0);
    pix(cx(0), cy(3), 1'b1, 1'b1, 1'b0, 1'b0);
    pix(cx(0), 45, 1'b1, 1'b1, 1'b0, 1'b0);
    pix(cx(0), cy(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pix(cx(3), cy(0), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_alive[3] = 1'b0; m_score += pts(0);
    chk("bnd_alive", 32'(alive_matrix), 32'(m_alive));
    chk("bnd_score", 32'(score), 32'(m_score));

    // Already-dead cell gives no hit
    kill(0, 1);

    // Bomb hit and respawn window
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t4_lives", 32'(lives), 2);
    chk("t4_dead", 32'(cannon_dead), 1);
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t4_invuln", 32'(lives), 2);
    repeat (58) tick();
    chk("t4_dead59", 32'(cannon_dead), 1);
    tick();
    chk("t4_dead60", 32'(cannon_dead), 0);
    chk("t4_lives_kept", 32'(lives), 2);

    // Second death -> lives 1, then clear all but the last alien
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t5_lives1", 32'(lives), 1);
    repeat (60) tick();
    for (int i = 0; i < 14; i++) if (m_alive[i]) kill(i / 5, i % 5);
    // Last-alien kill plus death in one frame: OVER wins
    pix(cx(4), cy(2), 1'b1, 1'b1, 1'b0, 1'b0);
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    m_score = (m_score + pts(2) > 255) ? 255 : m_score + pts(2);
    chk("t5_lives0", 32'(lives), 0);
    chk("t5_over", 32'(game_over), 1);
    chk("t5_alive", 32'(alive_matrix), 0);
    chk("t5_score", 32'(score), 32'(m_score));
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("over_hold", 32'(game_over), 1);
    chk("over_lives", 32'(lives), 0);
    @(negedge clk); restart = 1'b1;
    tick();
    restart = 1'b0;
    m_alive = 15'h7FFF; m_score = 0;
    chk("rs_over", 32'(game_over), 0);
    chk("rs_score", 32'(score), 0);
    chk("rs_lives", 32'(lives), 3);
    chk("rs_alive", 32'(alive_matrix), 32'h7FFF);
    chk("rs_dead", 32'(cannon_dead), 0);

    // Clear a full wave; bomb during WAVE ignored; reload after 90 ticks
    for (int i = 0; i < 15; i++) kill(i / 5, i % 5);
    chk("t6_over", 32'(game_over), 0);
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("t6_wave_bomb", 32'(lives), 3);
    repeat (88) tick();
    chk("t6_wave89", 32'(alive_matrix), 0);
    tick();
    m_alive = 15'h7FFF;
    chk("t6_reload", 32'(alive_matrix), 32'h7FFF);
    chk("t6_score", 32'(score), 32'(m_score));

    // Drive score to saturation across waves, then one more kill
    for (int n = 0; n < 400 && m_score < 255; n++) begin
      for (int i = 0; i < 15; i++) begin
        if (m_alive[i]) begin
          kill(i / 5, i % 5);
          break;
        end
      end
      if (m_alive == 15'h0) wave_wait();
    end
    kill(0, 0);
    chk("sat_score", 32'(score), 255);

    // Reset mid-frame drops pending detections
    pix(cx(1), cy(1), 1'b1, 1'b1, 1'b0, 1'b0);
    pix(200, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mr_alive", 32'(alive_matrix), 32'h7FFF);
    chk("mr_score", 32'(score), 0);
    rst_n = 1'b1;
    tick();
    m_alive = 15'h7FFF; m_score = 0;
    chk("mr_tick_alive", 32'(alive_matrix), 32'h7FFF);
    chk("mr_tick_lives", 32'(lives), 3);
    kill(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
